// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame strobe sequencer: state encoding,
// counter widths and the address-width helper.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

    localparam int PHASE_W = 4;
    localparam int COUNT_W = 16;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_seq_timer.sv
// Loadable phase down-counter. Holds at zero until reloaded; the zero
// flag marks the last cycle of the current phase.
module frame_seq_timer
    import frame_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               resetn,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               zero
);

    logic [PHASE_W-1:0] count;

    // Reload on phase entry, otherwise count down and stop at zero.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Write-side sequencer for the tile configuration frame latches.
// Accepts (address, word) pairs, presents the word on FrameData and pulses
// the one-hot FrameStrobe bit with programmable setup/strobe/hold timing.
// Optional build macro FRAME_ADDR_CHECK_EN: out-of-range addresses are
// rejected at the handshake and flagged on a sticky addr_err output.
//
//   state  | meaning
//   IDLE   | waiting for a pair, in_ready high
//   SETUP  | FrameData driven, strobe low
//   STROBE | FrameStrobe[addr] high
//   HOLD   | strobe low, FrameData still held
module frame_strobe_sequencer
    import frame_seq_pkg::*;
#(
    parameter  int MaxFramesPerCol = 20,
    parameter  int FrameBitsPerRow = 32,
    parameter  int SETUP_CYCLES    = 1,
    parameter  int STROBE_CYCLES   = 1,
    parameter  int HOLD_CYCLES     = 1,
    localparam int ADDR_W          = clog2(MaxFramesPerCol)
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [FrameBitsPerRow-1:0] in_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic [COUNT_W-1:0]         frames_written
`ifdef FRAME_ADDR_CHECK_EN
    ,
    output logic                       addr_err
`endif
);

    localparam logic [PHASE_W-1:0] SETUP_LEN  = PHASE_W'(SETUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] STROBE_LEN = PHASE_W'(STROBE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LEN   = PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

    seq_state_t                 state;
    seq_state_t                 state_next;
    logic [ADDR_W-1:0]          addr_q;
    logic                       addr_ok_q;
    logic                       in_range;
    logic                       accept;
    logic                       timer_load;
    logic [PHASE_W-1:0]         timer_val;
    logic                       timer_zero;
    logic                       count_inc;
    logic [MaxFramesPerCol-1:0] strobe_next;

    assign in_ready = (state == ST_IDLE) && resetn;
    assign in_range = int'(in_addr) < MaxFramesPerCol;

`ifdef FRAME_ADDR_CHECK_EN
    assign accept = in_valid && in_ready && in_range;
`else
    assign accept = in_valid && in_ready;
`endif

    frame_seq_timer u_timer (
        .CLK      (CLK),
        .resetn   (resetn),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state logic; the timer is reloaded on every phase entry.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = '0;
        count_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SETUP;
                    timer_load = 1'b1;
                    timer_val  = SETUP_LEN;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    state_next = ST_STROBE;
                    timer_load = 1'b1;
                    timer_val  = STROBE_LEN;
                end
            end
            ST_STROBE: begin
                if (timer_zero) begin
                    state_next = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = HOLD_LEN;
                    count_inc  = addr_ok_q;
                end
            end
            ST_HOLD: begin
                if (timer_zero) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobe is registered from the next state so it is glitch-free and
    // aligned exactly with the STROBE phase; bad addresses give no strobe.
    always_comb begin
        strobe_next = '0;
        if (state_next == ST_STROBE && addr_ok_q) strobe_next = STROBE_ONE << addr_q;
    end

    // Capture registers, registered outputs and the completion counter.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            FrameData      <= '0;
            FrameStrobe    <= '0;
            busy           <= 1'b0;
            frames_written <= '0;
            addr_q         <= '0;
            addr_ok_q      <= 1'b0;
        end else begin
            if (accept) begin
                FrameData <= in_data;
                addr_q    <= in_addr;
                addr_ok_q <= in_range;
            end
            FrameStrobe <= strobe_next;
            busy        <= (state_next != ST_IDLE);
            if (count_inc) frames_written <= frames_written + 1'b1;
        end
    end

`ifdef FRAME_ADDR_CHECK_EN
    // Sticky flag for a rejected out-of-range pair.
    always_ff @(posedge CLK) begin
        if (!resetn)                             addr_err <= 1'b0;
        else if (in_valid && in_ready && !in_range) addr_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Bench for frame_strobe_sequencer: one instance with default timing and
// one with setup=2/strobe=3/hold=2, both fed the same stimulus and compared
// against a timeline reference model (cycles elapsed since acceptance).
module tb_frame_strobe_sequencer;

    localparam int NF = 20;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [31:0] in_data;

    logic        rdy0, rdy1, busy0, busy1;
    logic [31:0] fd0, fd1;
    logic [19:0] fs0, fs1;
    logic [15:0] fw0, fw1;
    logic        err0, err1;

    logic        rdy [2];
    logic        bsy [2];
    logic [31:0] fd  [2];
    logic [19:0] fs  [2];
    logic [15:0] fw  [2];
    logic        err [2];

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    frame_strobe_sequencer dut0 (
        .CLK(CLK), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy0),
        .in_addr(in_addr), .in_data(in_data), .FrameData(fd0),
        .FrameStrobe(fs0), .busy(busy0), .frames_written(fw0)
`ifdef FRAME_ADDR_CHECK_EN
        , .addr_err(err0)
`endif
    );

    frame_strobe_sequencer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
        .CLK(CLK), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy1),
        .in_addr(in_addr), .in_data(in_data), .FrameData(fd1),
        .FrameStrobe(fs1), .busy(busy1), .frames_written(fw1)
`ifdef FRAME_ADDR_CHECK_EN
        , .addr_err(err1)
`endif
    );

`ifndef FRAME_ADDR_CHECK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    always_comb begin
        rdy[0] = rdy0;  rdy[1] = rdy1;
        bsy[0] = busy0; bsy[1] = busy1;
        fd[0]  = fd0;   fd[1]  = fd1;
        fs[0]  = fs0;   fs[1]  = fs1;
        fw[0]  = fw0;   fw[1]  = fw1;
        err[0] = err0;  err[1] = err1;
    end

    // ---------------- reference model ----------------
    int          ms [2] = '{1, 2};
    int          mp [2] = '{1, 3};
    int          mh [2] = '{1, 2};
    int          m_el   [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic [15:0] m_cnt  [2];
    logic        m_err  [2];

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_el[i] = 0; m_data[i] = '0; m_cnt[i] = '0; m_err[i] = 1'b0; m_addr[i] = '0;
            end else if (m_el[i] == 0) begin
                if (in_valid) begin
`ifdef FRAME_ADDR_CHECK_EN
                    if (in_addr >= NF) m_err[i] = 1'b1;
                    else begin m_el[i] = 1; m_addr[i] = in_addr; m_data[i] = in_data; end
`else
                    m_el[i] = 1; m_addr[i] = in_addr; m_data[i] = in_data;
`endif
                end
            end else begin
                if (m_el[i] == ms[i] + mp[i] && m_addr[i] < NF) m_cnt[i] = m_cnt[i] + 16'd1;
                m_el[i] = (m_el[i] == ms[i] + mp[i] + mh[i]) ? 0 : m_el[i] + 1;
            end
        end
    end

    function automatic logic [19:0] exp_fs(input int i);
        logic [19:0] one;
        one = 20'd1;
        if (m_el[i] > ms[i] && m_el[i] <= ms[i] + mp[i] && m_addr[i] < NF) return one << m_addr[i];
        return 20'd0;
    endfunction

    function automatic logic exp_rdy(input int i);
        return (m_el[i] == 0) && resetn;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            checks++; if (fd[i] !== 32'd0) begin failures++; $display("FAIL reset_data dut%0d got=%h exp=0", i, fd[i]); end
            checks++; if (fs[i] !== 20'd0) begin failures++; $display("FAIL reset_strobe dut%0d got=%h exp=0", i, fs[i]); end
            checks++; if (bsy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b exp=0", i, bsy[i]); end
            checks++; if (fw[i] !== 16'd0) begin failures++; $display("FAIL reset_count dut%0d got=%h exp=0", i, fw[i]); end
            checks++; if (rdy[i] !== 1'b0) begin failures++; $display("FAIL reset_ready_low dut%0d got=%b exp=0", i, rdy[i]); end
            checks++; if (err[i] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", i, err[i]); end
        end
        resetn = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (rdy[i] !== 1'b1) begin failures++; $display("FAIL reset_ready_high dut%0d got=%b exp=1", i, rdy[i]); end
        end
    endtask

    task automatic test_single();
        logic [19:0] want;
        @(negedge CLK);
        in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            in_valid = 1'b0; in_addr = 5'($urandom_range(0, 31)); in_data = $urandom;
            want = (k == 2) ? 20'h00008 : 20'h0;
            checks++; if (fd0 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data k=%0d got=%h exp=deadbeef", k, fd0); end
            checks++; if (fs0 !== want) begin failures++; $display("FAIL single_strobe k=%0d got=%h exp=%h", k, fs0, want); end
            checks++; if (rdy0 !== (k == 4)) begin failures++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, rdy0, (k == 4)); end
        end
        checks++; if (fw0 !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fw0); end
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_custom_timing();
        logic [31:0] d;
        logic [19:0] want;
        d = $urandom;
        @(negedge CLK);
        in_valid = 1'b1; in_addr = 5'd19; in_data = d;
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            want = (k >= 3 && k <= 5) ? 20'h80000 : 20'h0;
            if (k <= 8) begin
                checks++; if (fs1 !== want) begin failures++; $display("FAIL timing_strobe k=%0d got=%h exp=%h", k, fs1, want); end
            end
            if (k <= 7) begin
                checks++; if (fd1 !== d) begin failures++; $display("FAIL timing_data k=%0d got=%h exp=%h", k, fd1, d); end
            end
            checks++; if (rdy1 !== (k == 8)) begin failures++; $display("FAIL timing_ready k=%0d got=%b exp=%b", k, rdy1, (k == 8)); end
            if (k == 9) begin
                checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL timing_reaccept got=%b exp=1", busy1); end
            end
        end
        in_valid = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int          acc [4];
        int          j;
        logic [19:0] seen [$];
        logic [15:0] base;
        j = 0;
        @(negedge CLK);
        base = fw0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (fs0 != 20'd0) seen.push_back(fs0);
            checks++; if ($countones(fs0) > 1) begin failures++; $display("FAIL b2b_onehot cyc=%0d got=%h exp=<=1 bit", cyc, fs0); end
            for (int i = 0; i < 2; i++) begin
                checks++; if (fs[i] !== exp_fs(i)) begin failures++; $display("FAIL b2b_strobe dut%0d cyc=%0d got=%h exp=%h", i, cyc, fs[i], exp_fs(i)); end
                checks++; if (rdy[i] !== exp_rdy(i)) begin failures++; $display("FAIL b2b_ready dut%0d cyc=%0d got=%b exp=%b", i, cyc, rdy[i], exp_rdy(i)); end
            end
            if (rdy0) begin
                if (j < 4) begin
                    in_valid = 1'b1; in_addr = 5'(j); in_data = $urandom; acc[j] = cyc; j++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        checks++; if (j !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", j); end
        for (int n = 1; n < j; n++) begin
            checks++; if (acc[n] - acc[n-1] !== 4) begin failures++; $display("FAIL b2b_spacing n=%0d got=%0d exp=4", n, acc[n] - acc[n-1]); end
        end
        checks++; if (seen.size() !== 4) begin failures++; $display("FAIL b2b_strobe_count got=%0d exp=4", seen.size()); end
        for (int n = 0; n < seen.size() && n < 4; n++) begin
            checks++; if (seen[n] !== (20'd1 << n)) begin failures++; $display("FAIL b2b_order n=%0d got=%h exp=%h", n, seen[n], 20'd1 << n); end
        end
        checks++; if (fw0 !== base + 16'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", fw0, base + 16'd4); end
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset_mid_strobe();
        resetn = 1'b0;
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        in_valid = 1'b1; in_addr = 5'd5; in_data = $urandom;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        checks++; if (fs0 !== 20'h00020) begin failures++; $display("FAIL midrst_strobe_on got=%h exp=00020", fs0); end
        resetn = 1'b0;
        @(negedge CLK);
        checks++; if (fs0 !== 20'd0) begin failures++; $display("FAIL midrst_strobe_off got=%h exp=0", fs0); end
        checks++; if (fd0 !== 32'd0) begin failures++; $display("FAIL midrst_data got=%h exp=0", fd0); end
        checks++; if (fw0 !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", fw0); end
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL midrst_ready_low got=%b exp=0", rdy0); end
        resetn = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            checks++; if (rdy[i] !== 1'b1) begin failures++; $display("FAIL midrst_ready dut%0d got=%b exp=1", i, rdy[i]); end
            checks++; if (fw[i] !== m_cnt[i]) begin failures++; $display("FAIL midrst_model_count dut%0d got=%0d exp=%0d", i, fw[i], m_cnt[i]); end
            checks++; if (bsy[i] !== 1'b0) begin failures++; $display("FAIL midrst_busy dut%0d got=%b exp=0", i, bsy[i]); end
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] base;
        logic [31:0] prev;
        logic [31:0] d;
        @(negedge CLK);
        base = fw0; prev = fd0; d = $urandom;
        if (d == prev) d = ~prev;
        in_valid = 1'b1; in_addr = 5'd25; in_data = d;
        @(negedge CLK);
`ifdef FRAME_ADDR_CHECK_EN
        checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", err0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL oor_busy got=%b exp=0", busy0); end
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", rdy0); end
        checks++; if (fd0 !== prev) begin failures++; $display("FAIL oor_data got=%h exp=%h", fd0, prev); end
        in_addr = 5'd1;
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL oor_next_accept got=%b exp=1", busy0); end
        @(negedge CLK);
        checks++; if (fs0 !== 20'h00002) begin failures++; $display("FAIL oor_next_strobe got=%h exp=00002", fs0); end
        repeat (2) @(negedge CLK);
        checks++; if (fw0 !== base + 16'd1) begin failures++; $display("FAIL oor_next_count got=%0d exp=%0d", fw0, base + 16'd1); end
`else
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge CLK);
            checks++; if (fs0 !== 20'd0) begin failures++; $display("FAIL oor_strobe k=%0d got=%h exp=0", k, fs0); end
            checks++; if (busy0 !== (k < 4)) begin failures++; $display("FAIL oor_busy k=%0d got=%b exp=%b", k, busy0, (k < 4)); end
            checks++; if (fd0 !== d) begin failures++; $display("FAIL oor_data k=%0d got=%h exp=%h", k, fd0, d); end
        end
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", rdy0); end
        checks++; if (fw0 !== base) begin failures++; $display("FAIL oor_count got=%0d exp=%0d", fw0, base); end
`endif
        for (int i = 0; i < 2; i++) begin
            checks++; if (fw[i] !== m_cnt[i]) begin failures++; $display("FAIL oor_model_count dut%0d got=%0d exp=%0d", i, fw[i], m_cnt[i]); end
        end
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                checks++; if (fs[i] !== exp_fs(i)) begin failures++; $display("FAIL rnd_strobe dut%0d cyc=%0d got=%h exp=%h", i, cyc, fs[i], exp_fs(i)); end
                checks++; if (fd[i] !== m_data[i]) begin failures++; $display("FAIL rnd_data dut%0d cyc=%0d got=%h exp=%h", i, cyc, fd[i], m_data[i]); end
                checks++; if (rdy[i] !== exp_rdy(i)) begin failures++; $display("FAIL rnd_ready dut%0d cyc=%0d got=%b exp=%b", i, cyc, rdy[i], exp_rdy(i)); end
                checks++; if (bsy[i] !== (m_el[i] != 0)) begin failures++; $display("FAIL rnd_busy dut%0d cyc=%0d got=%b exp=%b", i, cyc, bsy[i], (m_el[i] != 0)); end
                checks++; if (fw[i] !== m_cnt[i]) begin failures++; $display("FAIL rnd_count dut%0d cyc=%0d got=%0d exp=%0d", i, cyc, fw[i], m_cnt[i]); end
                checks++; if ($countones(fs[i]) > 1) begin failures++; $display("FAIL rnd_onehot dut%0d cyc=%0d got=%h exp=<=1 bit", i, cyc, fs[i]); end
`ifdef FRAME_ADDR_CHECK_EN
                checks++; if (err[i] !== m_err[i]) begin failures++; $display("FAIL rnd_err dut%0d cyc=%0d got=%b exp=%b", i, cyc, err[i], m_err[i]); end
`endif
            end
            resetn   = ($urandom_range(0, 99) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
            in_data  = $urandom;
        end
        resetn = 1'b1; in_valid = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_wrap();
        @(negedge CLK);
        force dut0.frames_written = 16'hFFFF;
        force dut1.frames_written = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        m_cnt[1] = 16'hFFFF;
        @(negedge CLK);
        release dut0.frames_written;
        release dut1.frames_written;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            checks++; if (fw[i] !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload dut%0d got=%h exp=ffff", i, fw[i]); end
        end
        in_valid = 1'b1; in_addr = 5'd7; in_data = $urandom;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (9) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            checks++; if (fw[i] !== 16'h0000) begin failures++; $display("FAIL wrap_count dut%0d got=%h exp=0000", i, fw[i]); end
            checks++; if (fw[i] !== m_cnt[i]) begin failures++; $display("FAIL wrap_model dut%0d got=%h exp=%h", i, fw[i], m_cnt[i]); end
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        test_reset();
        test_single();
        test_custom_timing();
        test_back_to_back();
        test_reset_mid_strobe();
        test_out_of_range();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_strobe_sequencer.md
Name: frame_strobe_sequencer

Overview:
- Write-side controller for a tile configuration memory. Drives the FrameData and FrameStrobe inputs of the frame latches.
- Accepts (frame address, frame word) pairs over a valid/ready stream, typically from the bitstream loader.
- For each pair it holds the word on FrameData and pulses the one-hot FrameStrobe bit for that address, with programmable setup, strobe and hold timing.
- Guarantees that data is stable around every strobe edge and that at most one strobe bit is high at a time.

Parameters:
- MaxFramesPerCol, 20: number of frames per column; width of FrameStrobe.
- FrameBitsPerRow, 32: frame word width; width of FrameData.
- SETUP_CYCLES, 1: cycles FrameData is stable before the strobe rises; legal range 1..15.
- STROBE_CYCLES, 1: cycles the strobe is held high; legal range 1..15.
- HOLD_CYCLES, 1: cycles FrameData is held after the strobe falls; legal range 1..15.
- ADDR_W (derived), clog2(MaxFramesPerCol): address width; not overridable.

Ports:
- CLK, input, 1: single clock.
- resetn, input, 1: synchronous, active-low reset.
- in_valid, input, 1: address/data pair valid.
- in_ready, output, 1: sequencer can accept a pair.
- in_addr, input, ADDR_W: target frame index.
- in_data, input, FrameBitsPerRow: frame word.
- FrameData, output, FrameBitsPerRow: to the config memory frame latches.
- FrameStrobe, output, MaxFramesPerCol: one-hot latch enable.
- busy, output, 1: high in any state other than IDLE.
- frames_written, output, 16: count of completed strobes.

Behaviour:
- Interface decision: one clock, CLK; reset resetn is synchronous and active-low. All outputs are registered except in_ready.
- Reset values: FrameData=0, FrameStrobe=0, busy=0, frames_written=0, state=IDLE, phase counter=0.
- While resetn=0, in_ready=0.
- Reset mid-operation: the strobe drops at the reset edge, the in-flight word is discarded, and the counter is not incremented.
- in_ready = (state==IDLE) && resetn. It is combinational from state only and never depends on in_valid.
- Handshake: transfer occurs at an edge where in_valid && in_ready.
  - in_addr and in_data are captured at that edge.
  - The upstream block may change them after the transfer edge.
- State machine: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  - A 4-bit down-counter is loaded with (phase length - 1) on entry to each phase; the phase exits when the counter reaches 0.
- Timing, for a transfer at edge t:
  - FrameData = captured word from t+1 onward.
  - SETUP occupies cycles t+1 .. t+S.
  - STROBE occupies cycles t+S+1 .. t+S+P; FrameStrobe has only bit [addr] set (1<<addr).
  - HOLD occupies cycles t+S+P+1 .. t+S+P+H; FrameStrobe=0.
  - IDLE returns at t+S+P+H+1, and in_ready=1 in that same cycle.
  - Throughput: one word per 1+S+P+H cycles. Defaults give 4 cycles per word.
- FrameData retains its last value in IDLE and changes only on a new transfer.
- frames_written increments on the STROBE->HOLD transition. It is 16-bit and wraps from 0xFFFF to 0x0000.
- Out-of-range address (in_addr >= MaxFramesPerCol), without the optional feature:
  - The pair is accepted and the full SETUP/STROBE/HOLD sequence runs with FrameStrobe all zeros.
  - frames_written is not incremented.
- Back-to-back: in_valid held high gives a new transfer on every IDLE cycle. There is no bubble beyond the IDLE cycle itself.
- The FrameStrobe one-hot invariant holds in all states: popcount is 0, or 1 in STROBE only.

Optional Feature:
- Macro: FRAME_ADDR_CHECK_EN.
- Defined:
  - Extra output port addr_err (1 bit). It resets to 0, is set sticky at the accept edge of an out-of-range address, and is cleared only by reset.
  - The offending pair is dropped: the state stays IDLE, and in_ready remains 1 in the next cycle.
  - No FrameData update and no counter increment.
- Undefined: no addr_err port; out-of-range behaviour is as described in Behaviour.

Decomposition:
- Package frame_seq_pkg contains:
  - the state encoding (IDLE=0, SETUP=1, STROBE=2, HOLD=3);
  - the phase-counter width constant (4);
  - the frames_written width constant (16);
  - the clog2 function for ADDR_W.
- Sub-module frame_seq_timer: loadable 4-bit down-counter with a load value and a zero flag, instantiated once.
- Top: FSM, capture registers, one-hot decode, counter.

Test Plan:
- Reset, then one pair addr=3, data=0xDEADBEEF at edge t, with defaults:
  - FrameData=0xDEADBEEF from t+1;
  - FrameStrobe=0x00008 only during cycle t+2;
  - in_ready=1 at t+4;
  - frames_written=1.
- SETUP=2, STROBE=3, HOLD=2 with addr=19: strobe=0x80000 for exactly 3 cycles; data stable 2 cycles before and 2 cycles after; next accept at t+8.
- in_valid held high with 4 pairs (addr 0..3):
  - accepts exactly every 4 cycles;
  - strobes 0x1, 0x2, 0x4, 0x8 in order, never overlapping;
  - frames_written=4.
- resetn low during STROBE: FrameStrobe=0 at the next edge, FrameData=0, frames_written unchanged from its pre-word value, in_ready=1 one cycle after resetn rises.
- addr=25:
  - macro off: 4-cycle sequence, FrameStrobe stays 0, count unchanged;
  - macro on: addr_err=1, busy stays 0, a following addr=1 is accepted the next cycle and strobes 0x2.
- Preload 0xFFFF completions (force or long run), then one more write: frames_written wraps to 0x0000.
